w_handler: RTL

//   Generates AXI W-channel write-data beats for a burst of write transactions.

---
 rtl/w_handler.sv | 113 +++++++++++
 1 files changed

// File: rtl/w_handler.sv
// AXI W-channel beat generator: emits burst_len transactions of (len+1) beats each, data = seed + running beat count.
// Latency: first beat valid one cycle after enable_i; one beat per cycle; done_o one cycle after the final handshake.
// Backpressure: w_valid_o is held and data/strb/last stay frozen while w_ready_i is low.
module w_handler #(
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic [7:0]            burst_len_i,
    input  logic [7:0]            len_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic                  w_valid_o,
    input  logic                  w_ready_i,
    output logic [DATA_WIDTH-1:0] w_data_o,
    output logic [STRB_WIDTH-1:0] w_strb_o,
    output logic                  w_last_o
);

    typedef enum logic {
        IDLE,
        OPERATION
    } state_t;

    state_t                state_q;
    logic [7:0]            burst_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_cnt_q;
    logic [7:0]            trans_cnt_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [DATA_WIDTH-1:0] total_cnt_q;

    logic                  xfer;
    logic                  final_trans;
    logic [7:0]            beat_nxt;
    logic [DATA_WIDTH-1:0] total_nxt;

    assign xfer        = w_valid_o & w_ready_i;
    assign final_trans = (trans_cnt_q == burst_q - 8'd1);
    assign beat_nxt    = beat_cnt_q + 8'd1;
    assign total_nxt   = total_cnt_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    // Outputs are registered: each one is loaded with the value the counters will hold next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            burst_q     <= '0;
            len_q       <= '0;
            seed_q      <= '0;
            beat_cnt_q  <= '0;
            trans_cnt_q <= '0;
            total_cnt_q <= '0;
            ready_o     <= 1'b1;
            done_o      <= 1'b0;
            w_valid_o   <= 1'b0;
            w_data_o    <= '0;
            w_strb_o    <= '0;
            w_last_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        burst_q     <= burst_len_i;
                        len_q       <= len_i;
                        seed_q      <= seed_i;
                        beat_cnt_q  <= '0;
                        trans_cnt_q <= '0;
                        total_cnt_q <= '0;
                        if (burst_len_i != 8'd0) begin
                            state_q   <= OPERATION;
                            ready_o   <= 1'b0;
                            w_valid_o <= 1'b1;
                            w_data_o  <= seed_i;
                            w_strb_o  <= '1;
                            w_last_o  <= (len_i == 8'd0);
                        end else begin
                            done_o <= 1'b1;
                        end
                    end
                end
                OPERATION: begin
                    if (xfer) begin
                        total_cnt_q <= total_nxt;
                        w_data_o    <= seed_q + total_nxt;
                        if (w_last_o) begin
                            beat_cnt_q  <= '0;
                            trans_cnt_q <= trans_cnt_q + 8'd1;
                            if (final_trans) begin
                                state_q   <= IDLE;
                                ready_o   <= 1'b1;
                                done_o    <= 1'b1;
                                w_valid_o <= 1'b0;
                                w_strb_o  <= '0;
                                w_last_o  <= 1'b0;
                            end else begin
                                w_last_o <= (len_q == 8'd0);
                            end
                        end else begin
                            beat_cnt_q <= beat_nxt;
                            w_last_o   <= (beat_nxt == len_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
